// File: rtl/hiv_assay_pkg.sv
// rtl/hiv_assay_pkg.sv - shared types for the HIV-1 p24 assay valve sequencer
//   Exports: state_e (state codes double as the external step index),
//            V_* valve bit positions, valve_mask() state -> valve decode.
package hiv_assay_pkg;

  // Encoding is also the value driven on the step output; 0 = IDLE.
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LOAD1    = 4'd1,
    S_LOAD2    = 4'd2,
    S_LOAD3    = 4'd3,
    S_LOAD4    = 4'd4,
    S_FLUSH    = 4'd5,
    S_INCUBATE = 4'd6,
    S_DRAIN    = 4'd7,
    S_MARK     = 4'd8,
    S_CTRL     = 4'd9,
    S_GAP      = 4'd10,
    S_FINISH   = 4'd11
  } state_e;

  localparam int V_SRC1  = 0;
  localparam int V_SRC2  = 1;
  localparam int V_SRC3  = 2;
  localparam int V_SRC4  = 3;
  localparam int V_FLUSH = 4;
  localparam int V_DRAIN = 5;
  localparam int V_MARK  = 6;
  localparam int V_CTRL  = 7;

  // At most one bit set for any state, which is what keeps each junction single-inlet.
  function automatic logic [7:0] valve_mask(input state_e s);
    logic [7:0] m;
    m = '0;
    case (s)
      S_LOAD1: m[V_SRC1]  = 1'b1;
      S_LOAD2: m[V_SRC2]  = 1'b1;
      S_LOAD3: m[V_SRC3]  = 1'b1;
      S_LOAD4: m[V_SRC4]  = 1'b1;
      S_FLUSH: m[V_FLUSH] = 1'b1;
      S_DRAIN: m[V_DRAIN] = 1'b1;
      S_MARK:  m[V_MARK]  = 1'b1;
      S_CTRL:  m[V_CTRL]  = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/assay_step_timer.sv
// rtl/assay_step_timer.sv - loadable down-counter timing each sequencer step
//   clk_i, rst_i    : clock, asynchronous active-high reset
//   load_i          : load load_val_i (duration-1) on this edge
//   load_val_i [W]  : value to load
//   value_o    [W]  : current count
//   expire_o        : count has reached zero (last cycle of the step)
module assay_step_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] value_o,
  output logic         expire_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Saturates at zero so an idle timer stays expired.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o  = cnt_q;
  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/hiv_assay_valve_sequencer.sv
// rtl/hiv_assay_valve_sequencer.sv - timed valve sequencer for the p24 immunoassay chip
//   Optional feature macro: ASSAY_CONTROL_RUN_EN (adds CTRL step on v8 after MARK).
//   clk, rst (async, active-high)
//   start, abort        : level inputs
//   valve_open [8]      : bit i drives air line c(i+1), 1 = open
//   busy, done, aborted : status; done/aborted are one-cycle pulses
//   step [4]            : current step code (hiv_assay_pkg::state_e), 0 = IDLE
module hiv_assay_valve_sequencer
  import hiv_assay_pkg::*;
#(
  parameter int LOAD_CYCLES  = 64,
  parameter int MIX_CYCLES   = 1024,
  parameter int DRAIN_CYCLES = 128,
  parameter int MARK_CYCLES  = 64,
  parameter int CTRL_CYCLES  = 64,
  parameter int GAP_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic [7:0] valve_open,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic [3:0] step
);

  localparam int M1   = (LOAD_CYCLES  > MIX_CYCLES)  ? LOAD_CYCLES  : MIX_CYCLES;
  localparam int M2   = (DRAIN_CYCLES > MARK_CYCLES) ? DRAIN_CYCLES : MARK_CYCLES;
  localparam int M3   = (CTRL_CYCLES  > GAP_CYCLES)  ? CTRL_CYCLES  : GAP_CYCLES;
  localparam int M12  = (M1 > M2) ? M1 : M2;
  localparam int MAXP = (M12 > M3) ? M12 : M3;
  localparam int TW   = $clog2(MAXP) + 1;

  if (LOAD_CYCLES < 1 || MIX_CYCLES < 1 || DRAIN_CYCLES < 1 ||
      MARK_CYCLES < 1 || CTRL_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_duration
    $error("hiv_assay_valve_sequencer: every duration parameter must be >= 1");
  end

  function automatic logic [TW-1:0] dur_m1(input state_e s);
    case (s)
      S_LOAD1, S_LOAD2, S_LOAD3, S_LOAD4, S_FLUSH: return TW'(LOAD_CYCLES - 1);
      S_INCUBATE: return TW'(MIX_CYCLES - 1);
      S_DRAIN:    return TW'(DRAIN_CYCLES - 1);
      S_MARK:     return TW'(MARK_CYCLES - 1);
      S_CTRL:     return TW'(CTRL_CYCLES - 1);
      S_GAP:      return TW'(GAP_CYCLES - 1);
      default:    return '0;
    endcase
  endfunction

  state_e     state_q, state_d;
  state_e     gap_next_q, gap_next_d;  // where the shared GAP state resumes
  logic [7:0] valve_q, valve_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       aborted_q, aborted_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic [TW-1:0] tmr_value;
  logic          tmr_expire;
  logic          unused_tmr_value;

  assay_step_timer #(.W(TW)) u_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .value_o    (tmr_value),
    .expire_o   (tmr_expire)
  );

  assign unused_tmr_value = ^tmr_value;

  always_comb begin
    state_d    = state_q;
    gap_next_d = gap_next_q;
    aborted_d  = 1'b0;

    if (state_q == S_IDLE) begin
      // start beats a simultaneous abort: abort is meaningless in IDLE.
      if (start) state_d = S_LOAD1;
    end else if (state_q == S_FINISH) begin
      // done is already out; a late abort must not also raise aborted.
      state_d = S_IDLE;
    end else if (abort) begin
      state_d   = S_IDLE;
      aborted_d = 1'b1;
    end else if (tmr_expire) begin
      case (state_q)
        S_LOAD1:    begin state_d = S_GAP; gap_next_d = S_LOAD2;    end
        S_LOAD2:    begin state_d = S_GAP; gap_next_d = S_LOAD3;    end
        S_LOAD3:    begin state_d = S_GAP; gap_next_d = S_LOAD4;    end
        S_LOAD4:    begin state_d = S_GAP; gap_next_d = S_FLUSH;    end
        S_FLUSH:    begin state_d = S_GAP; gap_next_d = S_INCUBATE; end
        // Incubation already has every valve shut, so no settle gap is needed before DRAIN.
        S_INCUBATE: state_d = S_DRAIN;
        S_DRAIN:    begin state_d = S_GAP; gap_next_d = S_MARK;     end
`ifdef ASSAY_CONTROL_RUN_EN
        S_MARK:     begin state_d = S_GAP; gap_next_d = S_CTRL;     end
`else
        S_MARK:     begin state_d = S_GAP; gap_next_d = S_FINISH;   end
`endif
        S_CTRL:     begin state_d = S_GAP; gap_next_d = S_FINISH;   end
        S_GAP:      state_d = gap_next_q;
        default:    state_d = S_IDLE;
      endcase
    end

    tmr_load = (state_d != state_q);
    tmr_val  = dur_m1(state_d);

    // Outputs are decoded from the next state so the registers line up with state_q.
    valve_d = valve_mask(state_d);
`ifndef ASSAY_CONTROL_RUN_EN
    valve_d[V_CTRL] = 1'b0;
`endif
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FINISH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      gap_next_q <= S_IDLE;
      valve_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_next_q <= gap_next_d;
      valve_q    <= valve_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
    end
  end

  assign valve_open = valve_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign step       = state_q;

endmodule

// File: tb/tb_hiv_assay_valve_sequencer.sv
// tb/tb_hiv_assay_valve_sequencer.sv - self-checking bench for hiv_assay_valve_sequencer
module tb_hiv_assay_valve_sequencer;

  localparam int L = 3, MX = 10, DR = 4, MK = 2, CT = 2, GP = 1;
`ifdef ASSAY_CONTROL_RUN_EN
  localparam bit CTRL_EN = 1'b1;
`else
  localparam bit CTRL_EN = 1'b0;
`endif
  // Hand count: 5*3 + 5*1 + 10 + 4 + 1 + 2 + 1 = 38 cycles, FINISH is the 39th (+2+1 with CTRL).
  localparam int DONE_LAT = CTRL_EN ? 42 : 39;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] valve_open;
  logic       busy, done, aborted;
  logic [3:0] step;

  int n_checks = 0;
  int n_err = 0;

  hiv_assay_valve_sequencer #(
    .LOAD_CYCLES(L), .MIX_CYCLES(MX), .DRAIN_CYCLES(DR),
    .MARK_CYCLES(MK), .CTRL_CYCLES(CT), .GAP_CYCLES(GP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .valve_open(valve_open), .busy(busy), .done(done),
    .aborted(aborted), .step(step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: a run is a flat per-cycle script of expected outputs.
  typedef struct packed {
    logic [7:0] mask;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [3:0] step;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   len_pinned = 1'b0;

  task automatic push_seg(input logic [7:0] m, input logic [3:0] s, input int n);
    for (int i = 0; i < n; i++) q.push_back({m, 1'b1, 1'b0, 1'b0, s});
  endtask

  task automatic build_run();
    q.delete();
    push_seg(8'h01, 4'd1, L);  push_seg(8'h00, 4'd10, GP);
    push_seg(8'h02, 4'd2, L);  push_seg(8'h00, 4'd10, GP);
    push_seg(8'h04, 4'd3, L);  push_seg(8'h00, 4'd10, GP);
    push_seg(8'h08, 4'd4, L);  push_seg(8'h00, 4'd10, GP);
    push_seg(8'h10, 4'd5, L);  push_seg(8'h00, 4'd10, GP);
    push_seg(8'h00, 4'd6, MX);
    push_seg(8'h20, 4'd7, DR); push_seg(8'h00, 4'd10, GP);
    push_seg(8'h40, 4'd8, MK); push_seg(8'h00, 4'd10, GP);
    if (CTRL_EN) begin
      push_seg(8'h80, 4'd9, CT); push_seg(8'h00, 4'd10, GP);
    end
    q.push_back({8'h00, 1'b1, 1'b1, 1'b0, 4'd11});
  endtask

  initial begin
    cur = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        cur = '0;
      end else if (!cur.busy) begin
        if (start) begin
          build_run();
          if (!len_pinned) begin
            chk("model_len", 32'(q.size()), 32'(DONE_LAT));
            len_pinned = 1'b1;
          end
          cur = q.pop_front();
        end else begin
          cur = '0;
        end
      end else if (abort && !cur.done) begin
        q.delete();
        cur = '0;
        cur.aborted = 1'b1;
      end else if (q.size() != 0) begin
        cur = q.pop_front();
      end else begin
        cur = '0;
      end
    end
  end

  logic [7:0] prev_mask = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("valve_open", 32'(valve_open), 32'(cur.mask));
        chk("busy", 32'(busy), 32'(cur.busy));
        chk("done", 32'(done), 32'(cur.done));
        chk("aborted", 32'(aborted), 32'(cur.aborted));
        chk("step", 32'(step), 32'(cur.step));
        chk("popcount_le1", 32'($countones(valve_open) <= 1), 32'd1);
        if (prev_mask != 8'h00 && valve_open != 8'h00)
          chk("handover_gap", 32'(valve_open), 32'(prev_mask));
        prev_mask = valve_open;
      end else begin
        prev_mask = '0;
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_step(input logic [3:0] s, input string nm);
    int n;
    n = 0;
    while (step !== s && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(step), 32'(s));
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(done), 32'd1);
  endtask

  initial begin
    int  cnt;
    bit  seen;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valve", 32'(valve_open), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // Full run from a one-cycle start pulse.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 1;
    while (done !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("done_latency", 32'(cnt), 32'(DONE_LAT));
    @(negedge clk);
    chk("idle_after_done", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);

    // Abort in IDLE does nothing.
    abort = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_noop", 32'(aborted), 32'd0);

    // Abort during incubation, cycle 5.
    pulse_start();
    wait_step(4'd6, "reach_incubate");
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_pulse", 32'(aborted), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valves", 32'(valve_open), 32'd0);
    pulse_start();
    chk("restart_load1", 32'(step), 32'd1);
    wait_done("restart_done");
    repeat (2) @(negedge clk);

    // start and abort together in IDLE: start wins.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_wins_step", 32'(step), 32'd1);
    chk("start_wins_aborted", 32'(aborted), 32'd0);
    wait_done("start_wins_done");
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-DRAIN.
    pulse_start();
    wait_step(4'd7, "reach_drain");
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valve", 32'(valve_open), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("no_done_after_rst", 32'(seen), 32'd0);

    // start held high: back-to-back runs with one IDLE cycle between.
    start = 1'b1;
    wait_done("held_done1");
    @(negedge clk);
    chk("held_idle_gap", 32'(busy), 32'd0);
    @(negedge clk);
    chk("held_rerun", 32'(step), 32'd1);
    start = 1'b0;
    wait_step(4'd3, "reach_load3");
    pulse_start();
    wait_done("held_done2");
    // abort on the FINISH cycle is too late to count.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("finish_abort_ignored", 32'(aborted), 32'd0);
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
